// File: rtl/me_result_collector.sv
// Buffers motion-estimation results in a small first-word fall-through FIFO and
// tracks a block sequence number, a saturating frame SAD sum and a sticky drop flag.
module me_result_collector #(
  parameter int DEPTH     = 4,
  parameter int MV_OFFSET = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     data_valid,
  input  logic [13:0]              MSAD,
  input  logic [4:0]               MSAD_row,
  input  logic [4:0]               MSAD_column,
  output logic                     mv_valid,
  input  logic                     mv_ready,
  output logic [5:0]               mv_y,
  output logic [5:0]               mv_x,
  output logic [13:0]              sad_out,
  output logic [15:0]              blk_idx,
  output logic [$clog2(DEPTH):0]   level,
  output logic [19:0]              frame_sad,
  output logic                     overflow
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [5:0] OFFSET6 = 6'(MV_OFFSET);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] rd_idx;
  logic [15:0]   blk_cnt;
  logic [15:0]   blk_base;
  logic [19:0]   sad_base;
  logic [20:0]   sad_sum;
  logic [19:0]   sad_next;
  logic          full, empty, do_push, do_pop, drop;

  logic [13:0] sad_mem [DEPTH];
  logic [4:0]  row_mem [DEPTH];
  logic [4:0]  col_mem [DEPTH];
  logic [15:0] blk_mem [DEPTH];

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign mv_valid = !empty;
  assign rd_idx   = rd_ptr[AW-1:0];

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
  assign do_pop  = mv_valid & mv_ready;
  assign do_push = data_valid & (!full | do_pop);
  assign drop    = data_valid & full & !do_pop;

  // Clear takes effect before a same-cycle push, so that push starts the new frame.
  assign blk_base = clr_i ? 16'd0 : blk_cnt;
  assign sad_base = clr_i ? 20'd0 : frame_sad;
  assign sad_sum  = {1'b0, sad_base} + 21'(MSAD);
  assign sad_next = sad_sum[20] ? 20'hFFFFF : sad_sum[19:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      blk_cnt   <= '0;
      frame_sad <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      blk_cnt   <= do_push ? blk_base + 16'd1 : blk_base;
      frame_sad <= do_push ? sad_next : sad_base;
      overflow  <= (overflow & !clr_i) | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      sad_mem[wr_ptr[AW-1:0]] <= MSAD;
      row_mem[wr_ptr[AW-1:0]] <= MSAD_row;
      col_mem[wr_ptr[AW-1:0]] <= MSAD_column;
      blk_mem[wr_ptr[AW-1:0]] <= blk_base;
    end
  end

  // Storage is never reset, so the head is masked to zero whenever the FIFO is empty.
  always_comb begin
    mv_y    = '0;
    mv_x    = '0;
    sad_out = '0;
    blk_idx = '0;
    if (!empty) begin
      mv_y    = {1'b0, row_mem[rd_idx]} - OFFSET6;
      mv_x    = {1'b0, col_mem[rd_idx]} - OFFSET6;
      sad_out = sad_mem[rd_idx];
      blk_idx = blk_mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_me_result_collector.sv
// Directed self-checking bench for me_result_collector (DEPTH=4, MV_OFFSET=16).
module tb_me_result_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_i = 1'b0;
  logic        data_valid = 1'b0;
  logic [13:0] MSAD = '0;
  logic [4:0]  MSAD_row = '0;
  logic [4:0]  MSAD_column = '0;
  logic        mv_ready = 1'b0;
  logic        mv_valid;
  logic [5:0]  mv_y, mv_x;
  logic [13:0] sad_out;
  logic [15:0] blk_idx;
  logic [2:0]  level;
  logic [19:0] frame_sad;
  logic        overflow;

  int tests_run = 0;
  int tests_failed = 0;

  me_result_collector #(.DEPTH(4), .MV_OFFSET(16)) dut (
    .clk(clk), .rst(rst), .clr_i(clr_i), .data_valid(data_valid),
    .MSAD(MSAD), .MSAD_row(MSAD_row), .MSAD_column(MSAD_column),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_y(mv_y), .mv_x(mv_x),
    .sad_out(sad_out), .blk_idx(blk_idx), .level(level),
    .frame_sad(frame_sad), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [13:0] sad, input logic [4:0] row, input logic [4:0] col);
    data_valid  = 1'b1;
    MSAD        = sad;
    MSAD_row    = row;
    MSAD_column = col;
    step();
    data_valid  = 1'b0;
  endtask

  task automatic do_reset();
    mv_ready = 1'b0; data_valid = 1'b0; clr_i = 1'b0;
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (mv_valid !== 1'b0 || level !== 3'd0 || frame_sad !== 20'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got valid=%b level=%0d fsad=%0d ovf=%b want 0 0 0 0",
               mv_valid, level, frame_sad, overflow);
    end
    tests_run++;
    if (mv_x !== 6'd0 || mv_y !== 6'd0 || sad_out !== 14'd0 || blk_idx !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs got x=%h y=%h sad=%0d blk=%0d want all 0",
               mv_x, mv_y, sad_out, blk_idx);
    end
    #1 rst = 1'b1;
  endtask

  task automatic test_single_push();
    mv_ready = 1'b1;
    push(14'd100, 5'd16, 5'd20);
    tests_run++;
    if (mv_valid !== 1'b1 || mv_y !== 6'd0 || mv_x !== 6'd4 || sad_out !== 14'd100 || blk_idx !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL single_head got valid=%b y=%h x=%h sad=%0d blk=%0d want 1 00 04 100 0",
               mv_valid, mv_y, mv_x, sad_out, blk_idx);
    end
    step();
    tests_run++;
    if (level !== 3'd0 || mv_valid !== 1'b0 || frame_sad !== 20'd100) begin
      tests_failed++;
      $display("[TB] FAIL single_drain got level=%0d valid=%b fsad=%0d want 0 0 100",
               level, mv_valid, frame_sad);
    end
    mv_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(14'(10 * (i + 1)), 5'(i), 5'(31 - i));
      tests_run++;
      if (level !== 3'(i < 4 ? i + 1 : 4) || overflow !== (i == 4)) begin
        tests_failed++;
        $display("[TB] FAIL fill_%0d got level=%0d ovf=%b want %0d %b",
                 i, level, overflow, (i < 4 ? i + 1 : 4), (i == 4));
      end
    end
    tests_run++;
    if (frame_sad !== 20'd100) begin
      tests_failed++;
      $display("[TB] FAIL overflow_fsad got %0d want 100", frame_sad);
    end
    step();
    tests_run++;
    if (blk_idx !== 16'd0 || sad_out !== 14'd10 || mv_y !== 6'h30 || mv_x !== 6'd15) begin
      tests_failed++;
      $display("[TB] FAIL hold_head got blk=%0d sad=%0d y=%h x=%h want 0 10 30 0f",
               blk_idx, sad_out, mv_y, mv_x);
    end
    mv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (blk_idx !== 16'(i) || sad_out !== 14'(10 * (i + 1))) begin
        tests_failed++;
        $display("[TB] FAIL drain_%0d got blk=%0d sad=%0d want %0d %0d",
                 i, blk_idx, sad_out, i, 10 * (i + 1));
      end
      step();
    end
    tests_run++;
    if (level !== 3'd0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drained got level=%0d ovf=%b want 0 1", level, overflow);
    end
    mv_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) push(14'(i), 5'd16, 5'd16);
    mv_ready = 1'b1;
    push(14'd99, 5'd17, 5'd18);
    mv_ready = 1'b0;
    tests_run++;
    if (level !== 3'd4 || overflow !== 1'b0 || blk_idx !== 16'd1 || frame_sad !== 20'd109) begin
      tests_failed++;
      $display("[TB] FAIL full_push_pop got level=%0d ovf=%b blk=%0d fsad=%0d want 4 0 1 109",
               level, overflow, blk_idx, frame_sad);
    end
    mv_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tests_run++;
      if (blk_idx !== 16'(i) || sad_out !== 14'(i == 4 ? 99 : i + 1)) begin
        tests_failed++;
        $display("[TB] FAIL bb_drain_%0d got blk=%0d sad=%0d want %0d %0d",
                 i, blk_idx, sad_out, i, (i == 4 ? 99 : i + 1));
      end
      step();
    end
    mv_ready = 1'b0;
  endtask

  task automatic test_boundary();
    do_reset();
    mv_ready = 1'b1;
    data_valid = 1'b1; MSAD = 14'd16383; MSAD_row = 5'd0; MSAD_column = 5'd31;
    step();
    tests_run++;
    if (mv_y !== 6'b110000 || mv_x !== 6'd15) begin
      tests_failed++;
      $display("[TB] FAIL mv_extremes got y=%h x=%h want 30 0f", mv_y, mv_x);
    end
    for (int k = 2; k <= 200; k++) begin
      if (k == 200) begin MSAD_row = 5'd31; MSAD_column = 5'd0; end
      step();
      if (k == 64) begin
        tests_run++;
        if (frame_sad !== 20'd1048512) begin
          tests_failed++;
          $display("[TB] FAIL fsad_64 got %0d want 1048512", frame_sad);
        end
      end
      if (k == 65) begin
        tests_run++;
        if (frame_sad !== 20'd1048575) begin
          tests_failed++;
          $display("[TB] FAIL fsad_sat got %0d want 1048575", frame_sad);
        end
      end
    end
    data_valid = 1'b0;
    tests_run++;
    if (frame_sad !== 20'd1048575 || level !== 3'd1 || blk_idx !== 16'd199 ||
        mv_y !== 6'd15 || mv_x !== 6'b110000) begin
      tests_failed++;
      $display("[TB] FAIL stream_end got fsad=%0d level=%0d blk=%0d y=%h x=%h want 1048575 1 199 0f 30",
               frame_sad, level, blk_idx, mv_y, mv_x);
    end
    mv_ready = 1'b0;
  endtask

  task automatic test_clear();
    int exp_blk[4] = '{0, 1, 2, 0};
    int exp_sad[4] = '{11, 12, 13, 7};
    do_reset();
    push(14'd11, 5'd1, 5'd1);
    push(14'd12, 5'd2, 5'd2);
    push(14'd13, 5'd3, 5'd3);
    clr_i = 1'b1;
    push(14'd7, 5'd1, 5'd2);
    clr_i = 1'b0;
    tests_run++;
    if (level !== 3'd4 || frame_sad !== 20'd7 || overflow !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clr_push got level=%0d fsad=%0d ovf=%b want 4 7 0", level, frame_sad, overflow);
    end
    push(14'd50, 5'd4, 5'd4);
    tests_run++;
    if (level !== 3'd4 || frame_sad !== 20'd7 || overflow !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL drop_full got level=%0d fsad=%0d ovf=%b want 4 7 1", level, frame_sad, overflow);
    end
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    tests_run++;
    if (level !== 3'd4 || frame_sad !== 20'd0 || overflow !== 1'b0 || blk_idx !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL clr_only got level=%0d fsad=%0d ovf=%b blk=%0d want 4 0 0 0",
               level, frame_sad, overflow, blk_idx);
    end
    mv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (blk_idx !== 16'(exp_blk[i]) || sad_out !== 14'(exp_sad[i])) begin
        tests_failed++;
        $display("[TB] FAIL clr_drain_%0d got blk=%0d sad=%0d want %0d %0d",
                 i, blk_idx, sad_out, exp_blk[i], exp_sad[i]);
      end
      step();
    end
    mv_ready = 1'b0;
    push(14'd60, 5'd16, 5'd16);
    tests_run++;
    if (blk_idx !== 16'd0 || sad_out !== 14'd60 || level !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL post_clr_push got blk=%0d sad=%0d level=%0d want 0 60 1", blk_idx, sad_out, level);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(14'd21, 5'd5, 5'd6);
    push(14'd22, 5'd7, 5'd8);
    push(14'd23, 5'd9, 5'd10);
    tests_run++;
    if (level !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL pre_rst_level got %0d want 3", level);
    end
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (mv_valid !== 1'b0 || level !== 3'd0 || sad_out !== 14'd0 || blk_idx !== 16'd0 ||
        mv_x !== 6'd0 || mv_y !== 6'd0 || frame_sad !== 20'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_rst got valid=%b level=%0d sad=%0d blk=%0d x=%h y=%h fsad=%0d want all 0",
               mv_valid, level, sad_out, blk_idx, mv_x, mv_y, frame_sad);
    end
    #2 rst = 1'b1;
    step();
    tests_run++;
    if (mv_valid !== 1'b0 || sad_out !== 14'd0 || mv_y !== 6'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_after_rst got valid=%b sad=%0d y=%h want 0 0 00", mv_valid, sad_out, mv_y);
    end
    push(14'd55, 5'd17, 5'd15);
    tests_run++;
    if (blk_idx !== 16'd0 || mv_y !== 6'd1 || mv_x !== 6'h3F || sad_out !== 14'd55) begin
      tests_failed++;
      $display("[TB] FAIL first_after_rst got blk=%0d y=%h x=%h sad=%0d want 0 01 3f 55",
               blk_idx, mv_y, mv_x, sad_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_back_to_back();
    test_boundary();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
